// File: rtl/ps2_scancode_decoder_if.sv
// Receiver byte stream in, decoded key-event FIFO out.
// The decoder takes the slave side; whatever drives the keyboard bytes takes the master side.
interface ps2_scancode_decoder_if;
    logic [7:0] DATA;
    logic       DONE;
    logic       Rx_error;
    logic       rd_en;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_rel;
    logic       empty;
    logic       full;
    logic       overflow;

    modport master (
        output DATA, DONE, Rx_error, rd_en,
        input  ev_code, ev_ext, ev_rel, empty, full, overflow
    );

    modport slave (
        input  DATA, DONE, Rx_error, rd_en,
        output ev_code, ev_ext, ev_rel, empty, full, overflow
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-code decoder: turns PS/2 bytes (plain, E0-extended, F0-break) into
// key events queued in a small first-word-fall-through FIFO.
module ps2_scancode_decoder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    ps2_scancode_decoder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_e;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } event_t;

    // ------------------------------------------------------------------
    // Synchronisers; the third stage only remembers the previous value
    // so a held DONE produces a single strobe.
    // ------------------------------------------------------------------
    logic [2:0] done_sync_q;
    logic [2:0] err_sync_q;
    logic       strobe;
    logic       err_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_sync_q <= '0;
            err_sync_q  <= '0;
        end else begin
            done_sync_q <= {done_sync_q[1:0], bus.DONE};
            err_sync_q  <= {err_sync_q[1:0], bus.Rx_error};
        end
    end

    assign strobe   = done_sync_q[1] & ~done_sync_q[2];
    assign err_rise = err_sync_q[1] & ~err_sync_q[2];

    // ------------------------------------------------------------------
    // Prefix FSM with inter-byte timeout
    // ------------------------------------------------------------------
    state_e         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           push_q, push_d;
    event_t         push_ev_q, push_ev_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            push_q    <= 1'b0;
            push_ev_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            push_q    <= push_d;
            push_ev_q <= push_ev_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        push_d    = 1'b0;
        push_ev_d = '0;

        if (state_q != IDLE) begin
            timer_d = timer_q + TW'(1);
            if (timer_q == TW'(TIMEOUT - 1)) begin
                state_d = IDLE;
                timer_d = '0;
            end
        end

        // A line error abandons any partial sequence, even if a byte lands now.
        if (err_rise) begin
            state_d = IDLE;
            timer_d = '0;
        end else if (strobe) begin
            timer_d = '0;
            case (state_q)
                IDLE: begin
                    case (bus.DATA)
                        8'hE0: state_d = EXT;
                        8'hF0: state_d = BRK;
                        8'h00, 8'hAA, 8'hE1, 8'hEE,
                        8'hFA, 8'hFE, 8'hFF: state_d = IDLE;
                        default: begin
                            push_d    = 1'b1;
                            push_ev_d = '{ext: 1'b0, rel: 1'b0, code: bus.DATA};
                            state_d   = IDLE;
                        end
                    endcase
                end
                EXT: begin
                    case (bus.DATA)
                        8'hF0: state_d = EXT_BRK;
                        8'hE0: state_d = EXT;
                        default: begin
                            push_d    = 1'b1;
                            push_ev_d = '{ext: 1'b1, rel: 1'b0, code: bus.DATA};
                            state_d   = IDLE;
                        end
                    endcase
                end
                BRK: begin
                    push_d    = (bus.DATA != 8'hF0) && (bus.DATA != 8'hE0);
                    push_ev_d = '{ext: 1'b0, rel: 1'b1, code: bus.DATA};
                    state_d   = IDLE;
                end
                EXT_BRK: begin
                    push_d    = (bus.DATA != 8'hF0) && (bus.DATA != 8'hE0);
                    push_ev_d = '{ext: 1'b1, rel: 1'b1, code: bus.DATA};
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO: extra pointer bit distinguishes full from empty.
    // ------------------------------------------------------------------
    event_t         mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic           empty_q, empty_d;
    logic           full_q, full_d;
    logic           ovf_q, ovf_d;
    logic           pop;
    logic           wr_en;
    event_t         head;

    assign pop   = bus.rd_en & ~empty_q;
    assign wr_en = push_q & (~full_q | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        ovf_d    = ovf_q | (push_q & full_q & ~pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is reset so the head reads as all-zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_ev_q;
        end
    end

    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.ev_code  = head.code;
    assign bus.ev_ext   = head.ext;
    assign bus.ev_rel   = head.rel;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed scan-code sequences plus randomized
// byte/error/pop traffic against a queue-based event model.
module tb_ps2_scancode_decoder;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 50000;

    logic clk;
    logic reset;

    ps2_scancode_decoder_if bus ();

    ps2_scancode_decoder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: pending prefix flags and an ordered list of {ext,rel,code}.
    logic [9:0] mq [$];
    logic       m_ovf;
    logic       m_ext;
    logic       m_brk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_ignored(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    endfunction

    task automatic model_push(input logic [9:0] ev);
        if (mq.size() < DEPTH) mq.push_back(ev);
        else m_ovf = 1'b1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0 || b == 8'hF0) begin
            if (m_brk) begin
                m_ext = 1'b0;
                m_brk = 1'b0;
            end else if (b == 8'hE0) m_ext = 1'b1;
            else m_brk = 1'b1;
        end else begin
            if (m_ext || m_brk || !is_ignored(b)) model_push({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".empty"}, 32'(bus.empty), 32'(mq.size() == 0));
        chk({tag, ".full"}, 32'(bus.full), 32'(mq.size() == DEPTH));
        chk({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
        if (mq.size() > 0)
            chk({tag, ".head"}, 32'({bus.ev_ext, bus.ev_rel, bus.ev_code}), 32'(mq[0]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.DONE = 1'b0;
        bus.Rx_error = 1'b0;
        bus.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.DATA = b;
        bus.DONE = 1'b1;
        repeat (4) @(negedge clk);
        bus.DONE = 1'b0;
        repeat (4) @(negedge clk);
        model_byte(b);
    endtask

    task automatic err_pulse();
        @(negedge clk);
        bus.Rx_error = 1'b1;
        repeat (4) @(negedge clk);
        bus.Rx_error = 1'b0;
        repeat (4) @(negedge clk);
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        @(negedge clk);
        if (mq.size() > 0)
            chk({tag, ".pop"}, 32'({bus.ev_ext, bus.ev_rel, bus.ev_code}), 32'(mq[0]));
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
        check_status(tag);
    endtask

    initial begin
        reset = 1'b1;
        bus.DATA = 8'h00;
        bus.DONE = 1'b0;
        bus.Rx_error = 1'b0;
        bus.rd_en = 1'b0;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst.empty", 32'(bus.empty), 32'd1);
        chk("rst.full", 32'(bus.full), 32'd0);
        chk("rst.ovf", 32'(bus.overflow), 32'd0);
        chk("rst.head", 32'({bus.ev_ext, bus.ev_rel, bus.ev_code}), 32'd0);

        // Held DONE: latency and single strobe
        bus.DATA = 8'h1C;
        bus.DONE = 1'b1;
        repeat (3) @(negedge clk);
        chk("lat.edge3", 32'(bus.empty), 32'd1);
        @(negedge clk);
        chk("lat.edge4", 32'(bus.empty), 32'd0);
        repeat (96) @(negedge clk);
        bus.DONE = 1'b0;
        repeat (4) @(negedge clk);
        model_byte(8'h1C);
        check_status("held");
        pop_check("held");

        // Basic sequences, popped in arrival order
        send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        chk("seq.n4full", 32'(bus.full), 32'd1);
        chk("seq.h0", 32'({bus.ev_ext, bus.ev_rel, bus.ev_code}), 32'h01C);
        pop_check("seq1");
        chk("seq.h1", 32'({bus.ev_ext, bus.ev_rel, bus.ev_code}), 32'h11C);
        pop_check("seq2");
        chk("seq.h2", 32'({bus.ev_ext, bus.ev_rel, bus.ev_code}), 32'h275);
        pop_check("seq3");
        chk("seq.h3", 32'({bus.ev_ext, bus.ev_rel, bus.ev_code}), 32'h375);
        pop_check("seq4");

        // Timeout clears E0 prefix
        send_byte(8'hE0);
        repeat (60000) @(negedge clk);
        m_ext = 1'b0;
        m_brk = 1'b0;
        send_byte(8'h1C);
        chk("tmo.head", 32'({bus.ev_ext, bus.ev_rel, bus.ev_code}), 32'h01C);
        pop_check("tmo");

        // Rx_error clears F0 prefix
        send_byte(8'hF0);
        err_pulse();
        send_byte(8'h1C);
        chk("err.head", 32'({bus.ev_ext, bus.ev_rel, bus.ev_code}), 32'h01C);
        pop_check("err");

        // Ignored codes in IDLE
        send_byte(8'hAA); send_byte(8'hFA); send_byte(8'h00); send_byte(8'hFF);
        chk("ign.empty", 32'(bus.empty), 32'd1);

        // Overflow: 5 pushes into DEPTH=4
        for (int i = 1; i <= 5; i++) send_byte(8'(8'h10 + i));
        chk("ovf.full", 32'(bus.full), 32'd1);
        chk("ovf.flag", 32'(bus.overflow), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf.order", 32'(bus.ev_code), 32'(8'h10 + i));
            pop_check("ovf");
        end
        chk("ovf.empty", 32'(bus.empty), 32'd1);
        chk("ovf.sticky", 32'(bus.overflow), 32'd1);

        // Push and pop in the same cycle while full
        do_reset();
        for (int i = 1; i <= 4; i++) send_byte(8'(8'h20 + i));
        @(negedge clk);
        bus.DATA = 8'h26;
        bus.DONE = 1'b1;
        repeat (3) @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        void'(mq.pop_front());
        mq.push_back({2'b00, 8'h26});
        chk("pp.ovf", 32'(bus.overflow), 32'd0);
        chk("pp.full", 32'(bus.full), 32'd1);
        bus.DONE = 1'b0;
        repeat (4) @(negedge clk);
        check_status("pp");
        while (mq.size() > 0) pop_check("pp.drain");

        // Reset mid-sequence discards the prefix
        send_byte(8'hE0);
        do_reset();
        @(negedge clk);
        chk("rstmid.empty", 32'(bus.empty), 32'd1);
        send_byte(8'h1C);
        chk("rstmid.head", 32'({bus.ev_ext, bus.ev_rel, bus.ev_code}), 32'h01C);
        pop_check("rstmid");

        // Randomized traffic
        for (int it = 0; it < 250; it++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 11);
            case (r)
                0, 1: send_byte(8'hE0);
                2, 3: send_byte(8'hF0);
                4: begin
                    case ($urandom_range(0, 6))
                        0: b = 8'h00;
                        1: b = 8'hAA;
                        2: b = 8'hE1;
                        3: b = 8'hEE;
                        4: b = 8'hFA;
                        5: b = 8'hFE;
                        default: b = 8'hFF;
                    endcase
                    send_byte(b);
                end
                5: err_pulse();
                6, 7, 8: pop_check("rnd.pop");
                default: send_byte(8'($urandom_range(0, 255)));
            endcase
            check_status("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
